// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DROP  = 3'd4,
    FAULT = 3'd5,
    HALT  = 3'd6
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: redirect input, imem req/gnt/rvalid port, decode valid/ready port.
interface fetch_controller_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
);
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  logic             imem_req;
  logic [DEPTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;

  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr_data;
  logic [XLEN-1:0]  instr_pc;
  logic             instr_fault;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr_data, instr_pc, instr_fault,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr_data, instr_pc, instr_fault,
    output instr_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one imem read at a time,
// hands instructions to decode and turns bad fetch addresses into a NOP fault.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  fetch_controller_if.master bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            valid_q, fault_q;
  logic [31:0]     data_q;
  logic [XLEN-1:0] out_pc_q;

  logic go_req, load_instr, load_fault, clr_valid;

  function automatic logic pc_bad(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00) || (|pc[XLEN-1:DEPTH+2]);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    go_req     = 1'b0;
    load_instr = 1'b0;
    load_fault = 1'b0;
    clr_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        go_req = 1'b1;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_gnt) state_d = DROP;
          else              go_req  = 1'b1;
        end else if (bus.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_rvalid) go_req  = 1'b1;
          else                 state_d = DROP;
        end else if (bus.imem_rvalid) begin
          load_instr = 1'b1;
          pc_d       = pc_q + XLEN'(PC_STEP);
          state_d    = OUT;
        end
      end
      OUT: begin
        if (bus.redirect_valid) begin
          pc_d      = bus.redirect_pc;
          clr_valid = 1'b1;
          go_req    = 1'b1;
        end else if (bus.instr_ready) begin
          clr_valid = 1'b1;
          go_req    = 1'b1;
        end
      end
      FAULT: begin
        if (bus.redirect_valid) begin
          pc_d      = bus.redirect_pc;
          clr_valid = 1'b1;
          go_req    = 1'b1;
        end else if (bus.instr_ready) begin
          clr_valid = 1'b1;
          state_d   = HALT;
        end
      end
      DROP: begin
        // A redirect coinciding with the stale response still retires it,
        // otherwise we would wait forever for a second rvalid.
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (bus.imem_rvalid)    go_req = 1'b1;
      end
      HALT: begin
        if (bus.redirect_valid) begin
          pc_d   = bus.redirect_pc;
          go_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every entry into REQ screens the target PC first.
    if (go_req) begin
      if (pc_bad(pc_d)) begin
        state_d    = FAULT;
        load_fault = 1'b1;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      data_q   <= '0;
      out_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_fault) begin
        valid_q  <= 1'b1;
        fault_q  <= 1'b1;
        data_q   <= NOP_INSTR;
        out_pc_q <= pc_d;
      end else if (load_instr) begin
        valid_q  <= 1'b1;
        fault_q  <= 1'b0;
        data_q   <= bus.imem_rdata;
        out_pc_q <= pc_q;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = (state_q == REQ) ? pc_q[DEPTH+1:2] : '0;
  assign bus.instr_valid = valid_q;
  assign bus.instr_fault = fault_q;
  assign bus.instr_data  = data_q;
  assign bus.instr_pc    = out_pc_q;

endmodule
